// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU select codes, decode constants and execute-stage states
package alu_pkg;
  typedef enum logic [4:0] {
    SEL_ADD    = 5'h00,
    SEL_SUB    = 5'h01,
    SEL_AND    = 5'h02,
    SEL_OR     = 5'h03,
    SEL_XOR    = 5'h04,
    SEL_SLL    = 5'h05,
    SEL_SRL    = 5'h06,
    SEL_SRA    = 5'h07,
    SEL_SLT    = 5'h08,
    SEL_SLTU   = 5'h09,
    SEL_MUL    = 5'h10,
    SEL_MULH   = 5'h11,
    SEL_MULHSU = 5'h12,
    SEL_MULHU  = 5'h13,
    SEL_DIV    = 5'h14,
    SEL_DIVU   = 5'h15,
    SEL_REM    = 5'h16,
    SEL_REMU   = 5'h17
  } alu_sel_t;
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational {alu_op, funct7, funct3} -> alu_sel_t + illegal; MEXT_DIV_EN enables DIV/REM decode
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [6:0] i_funct7,
  input  logic [2:0] i_funct3,
  output alu_sel_t   o_sel,
  output logic       o_illegal
);
  logic w_any;
  assign w_any = i_alu_op != 2'b11;
  always_comb begin
    o_sel = SEL_ADD;
    o_illegal = 1'b0;
    // shift encodings take priority over the mem/branch defaults
    if (w_any && i_funct3 == 3'b001 && i_funct7 == F7_BASE) o_sel = SEL_SLL;
    else if (w_any && i_funct3 == 3'b101 && i_funct7 == F7_BASE) o_sel = SEL_SRL;
    else if (w_any && i_funct3 == 3'b101 && i_funct7 == F7_ALT) o_sel = SEL_SRA;
    else if (i_alu_op == ALUOP_MEM) o_sel = SEL_ADD;
    else if (i_alu_op == ALUOP_BR) begin
      o_sel = i_funct3[2] ? (i_funct3[1] ? SEL_SLTU : SEL_SLT) : SEL_SUB;
      o_illegal = i_funct3[2:1] == 2'b01;
    end else if (i_alu_op == ALUOP_R && i_funct7 == F7_BASE) begin
      case (i_funct3)
        3'b001:  o_sel = SEL_SLL;
        3'b010:  o_sel = SEL_SLT;
        3'b011:  o_sel = SEL_SLTU;
        3'b100:  o_sel = SEL_XOR;
        3'b101:  o_sel = SEL_SRL;
        3'b110:  o_sel = SEL_OR;
        3'b111:  o_sel = SEL_AND;
        default: o_sel = SEL_ADD;
      endcase
    end else if (i_alu_op == ALUOP_R && i_funct7 == F7_ALT) begin
      o_sel = SEL_SUB;
      o_illegal = i_funct3 != 3'b000;
    end else if (i_alu_op == ALUOP_R && i_funct7 == F7_MEXT) begin
      o_sel = alu_sel_t'({2'b10, i_funct3});
`ifdef MEXT_DIV_EN
      o_illegal = 1'b0;
`else
      o_illegal = i_funct3[2];
`endif
    end else o_illegal = 1'b1;
  end
endmodule

// File: rtl/alu_exec_mext.sv
// alu_exec_mext: registered EX stage with iterative RV M-extension; MEXT_DIV_EN compiles the divider
module alu_exec_mext
  import alu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);
  state_t r_state, w_next;
  alu_sel_t w_sel, r_sel;
  logic w_illegal, w_accept, w_direct, w_special, w_sa, w_sb;
  logic r_neg, r_zero, r_illegal;
  logic [SHAMT_W:0] r_cnt;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0] r_a, r_hi, r_lo, r_result;
  logic [XLEN-1:0] w_base, w_spec_res, w_direct_res, w_ma, w_mb, w_mres, w_cres;
  logic [XLEN:0] w_sum;
  logic [2*XLEN-1:0] w_prod;
  alu_decode u_dec (
    .i_alu_op (alu_op),
    .i_funct7 (funct7),
    .i_funct3 (funct3),
    .o_sel    (w_sel),
    .o_illegal(w_illegal)
  );
  assign in_ready  = r_state == IDLE;
  assign busy      = r_state == CALC;
  assign out_valid = r_state == DONE;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;
  assign w_accept  = in_valid & in_ready;
  assign w_shamt   = op_b[SHAMT_W-1:0];
  always_comb begin
    case (w_sel)
      SEL_SUB:  w_base = op_a - op_b;
      SEL_AND:  w_base = op_a & op_b;
      SEL_OR:   w_base = op_a | op_b;
      SEL_XOR:  w_base = op_a ^ op_b;
      SEL_SLL:  w_base = op_a << w_shamt;
      SEL_SRL:  w_base = op_a >> w_shamt;
      SEL_SRA:  w_base = $signed(op_a) >>> w_shamt;
      SEL_SLT:  w_base = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      SEL_SLTU: w_base = {{(XLEN-1){1'b0}}, op_a < op_b};
      default:  w_base = op_a + op_b;
    endcase
  end
`ifdef MEXT_DIV_EN
  logic w_b_zero, w_ovf;
  logic [XLEN:0] w_rem, w_diff;
  assign w_b_zero   = op_b == '0;
  assign w_ovf      = (w_sel == SEL_DIV || w_sel == SEL_REM) && op_a == {1'b1, {(XLEN-1){1'b0}}} && &op_b;
  assign w_special  = w_sel[4] & w_sel[2] & (w_b_zero | w_ovf);
  assign w_spec_res = w_b_zero ? (w_sel[1] ? op_a : '1) : (w_sel[1] ? '0 : op_a);
  assign w_rem      = {r_hi, r_lo[XLEN-1]};
  assign w_diff     = w_rem - {1'b0, r_a};
`else
  assign w_special  = 1'b0;
  assign w_spec_res = '0;
`endif
  assign w_direct     = w_illegal | ~w_sel[4] | w_special;
  assign w_direct_res = w_illegal ? '0 : (w_sel[4] ? w_spec_res : w_base);
  // operands are iterated as magnitudes; r_neg records the sign fix-up
  assign w_sa = op_a[XLEN-1] & (w_sel == SEL_MULH || w_sel == SEL_MULHSU || w_sel == SEL_DIV || w_sel == SEL_REM);
  assign w_sb = op_b[XLEN-1] & (w_sel == SEL_MULH || w_sel == SEL_DIV || w_sel == SEL_REM);
  assign w_ma = w_sa ? -op_a : op_a;
  assign w_mb = w_sb ? -op_b : op_b;
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_mres = r_sel == SEL_MUL ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
`ifdef MEXT_DIV_EN
  assign w_cres = r_sel[2] ? (r_sel[1] ? (r_neg ? -r_hi : r_hi) : (r_neg ? -r_lo : r_lo)) : w_mres;
`else
  assign w_cres = w_mres;
`endif
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && in_valid) w_next = w_direct ? DONE : CALC;
    if (r_state == CALC && r_cnt == '0) w_next = DONE;
    if (r_state == DONE && out_ready) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_sel     <= w_sel;
        r_neg     <= w_sel == SEL_REM ? w_sa : w_sa ^ w_sb;
        r_a       <= w_sel[2] ? w_mb : w_ma;
        r_lo      <= w_sel[2] ? w_ma : w_mb;
        r_hi      <= '0;
        r_cnt     <= (SHAMT_W+1)'(XLEN);
        r_result  <= w_direct_res;
        r_zero    <= w_direct_res == '0;
        r_illegal <= w_illegal;
      end else if (r_state == CALC) begin
        if (r_cnt == '0) begin
          r_result <= w_cres;
          r_zero   <= w_cres == '0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
`ifdef MEXT_DIV_EN
          if (r_sel[2]) begin
            r_hi <= w_diff[XLEN] ? w_rem[XLEN-1:0] : w_diff[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], ~w_diff[XLEN]};
          end else
`endif
          begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_mext.sv
// tb_alu_exec_mext: directed + random checks of alu_exec_mext (XLEN=32) against an arithmetic reference model
module tb_alu_exec_mext;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, zero, illegal, busy;
  logic [1:0] alu_op = '0;
  logic [6:0] funct7 = '0;
  logic [2:0] funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0, result;
  int checks = 0, errors = 0;
  alu_exec_mext #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .illegal(illegal), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // lat = clock edges between the accept edge and out_valid rising
  function automatic void model(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    logic [4:0] sh;
    longint p;
    logic [63:0] pu;
    int ia, ib;
    sh = b[4:0];
    ia = $signed(a);
    ib = $signed(b);
    r = '0;
    ill = 1'b0;
    lat = 0;
    if (op != 2'b11 && f3 == 3'b001 && f7 == 7'h00) r = a << sh;
    else if (op != 2'b11 && f3 == 3'b101 && f7 == 7'h00) r = a >> sh;
    else if (op != 2'b11 && f3 == 3'b101 && f7 == 7'h20) r = $signed(a) >>> sh;
    else if (op == 2'b00) r = a + b;
    else if (op == 2'b01) begin
      if (f3 <= 3'd1) r = a - b;
      else if (f3 == 3'd4 || f3 == 3'd5) r = (ia < ib) ? 32'd1 : 32'd0;
      else if (f3 >= 3'd6) r = (a < b) ? 32'd1 : 32'd0;
      else ill = 1'b1;
    end else if (op == 2'b10 && f7 == 7'h00) begin
      if (f3 == 3'd0) r = a + b;
      else if (f3 == 3'd2) r = (ia < ib) ? 32'd1 : 32'd0;
      else if (f3 == 3'd3) r = (a < b) ? 32'd1 : 32'd0;
      else if (f3 == 3'd4) r = a ^ b;
      else if (f3 == 3'd6) r = a | b;
      else r = a & b;
    end else if (op == 2'b10 && f7 == 7'h20 && f3 == 3'd0) r = a - b;
    else if (op == 2'b10 && f7 == 7'h01 && f3 < 3'd4) begin
      lat = 33;
      if (f3 == 3'd0) begin pu = {32'h0, a} * {32'h0, b}; r = pu[31:0]; end
      else if (f3 == 3'd1) begin p = longint'(ia) * longint'(ib); r = p[63:32]; end
      else if (f3 == 3'd2) begin p = longint'(ia) * longint'({32'h0, b}); r = p[63:32]; end
      else begin pu = {32'h0, a} * {32'h0, b}; r = pu[63:32]; end
    end else if (op == 2'b10 && f7 == 7'h01) begin
`ifdef MEXT_DIV_EN
      lat = (b == 0 || (f3[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 0 : 33;
      if (f3 == 3'd4) r = (b == 0) ? 32'hFFFF_FFFF : (lat == 0 ? a : ia / ib);
      else if (f3 == 3'd5) r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      else if (f3 == 3'd6) r = (b == 0) ? a : (lat == 0 ? 32'h0 : ia % ib);
      else r = (b == 0) ? a : a % b;
`else
      ill = 1'b1;
`endif
    end else ill = 1'b1;
    if (ill) r = '0;
  endfunction
  task automatic run_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [31:0] er;
    logic ei;
    int el, n;
    model(op, f7, f3, a, b, er, ei, el);
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check("in_ready_idle", in_ready, 1);
    alu_op = op; funct7 = f7; funct3 = f3; op_a = a; op_b = b;
    in_valid = 1'b1;
    out_ready = !hold;
    @(posedge clk);
    #1;
    alu_op = 2'($urandom); funct7 = 7'($urandom); funct3 = 3'($urandom);
    op_a = $urandom; op_b = $urandom;
    @(negedge clk);
    n = 0;
    if (el > 0) begin
      check("busy_calc", busy, 1);
      check("in_ready_calc", in_ready, 0);
    end
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    in_valid = 1'b0;
    check("latency", n, el);
    check("result", result, er);
    check("illegal", illegal, ei);
    check("zero", zero, er == 0);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_result", result, er);
        check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("release_valid", out_valid, 0);
  endtask
  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic [1:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    int n;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_illegal", illegal, 0);
    reset = 1'b0;
    @(negedge clk);
    run_op(2'b00, 7'h00, 3'b000, 32'd5, 32'd7, 1'b0);
    run_op(2'b01, 7'h00, 3'b000, 32'd9, 32'd9, 1'b0);
    run_op(2'b10, 7'h20, 3'b101, 32'h8000_0000, 32'h24, 1'b0);
    run_op(2'b10, 7'h3F, 3'b000, 32'd1, 32'd2, 1'b0);
    run_op(2'b10, 7'h01, 3'b001, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_op(2'b10, 7'h01, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 7'h01, 3'b000, 32'd6, 32'd7, 1'b0);
    run_op(2'b10, 7'h01, 3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b10, 7'h01, 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b10, 7'h01, 3'b101, 32'd7, 32'd0, 1'b0);
    run_op(2'b10, 7'h01, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 7'h00, 3'b100, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
    run_op(2'b10, 7'h01, 3'b010, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1);
    alu_op = 2'b10; funct7 = 7'h01; funct3 = 3'b000; op_a = 32'd11; op_b = 32'd13;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (n = 1; n <= 10; n++) @(negedge clk);
    check("calc10_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_result", result, 0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin op = 2'b10; f7 = 7'h01; end
        4, 5:       begin op = 2'b10; f7 = 7'h00; end
        6:          begin op = 2'b10; f7 = 7'h20; end
        7:          begin op = 2'b00; f7 = $urandom_range(0, 1) ? 7'h00 : 7'h20; end
        8:          begin op = 2'b01; f7 = 7'h00; end
        default:    begin op = 2'($urandom); f7 = 7'($urandom); end
      endcase
      f3 = 3'($urandom);
      run_op(op, f7, f3, pick_operand(), pick_operand(), i % 9 == 4);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_mext.md
Name: alu_exec_mext

Overview:
- Parametrised successor to the combinational ALU-control decoder. It merges ALUop/funct7/funct3 decode with a registered execute stage.
- Adds the RV M-extension: MUL, MULH, MULHSU, MULHU, and the DIV/REM family.
- Multiply and divide are iterative and multi-cycle, with valid/ready handshakes on both sides.
- Sits in the EX stage between the decode/register-read stage and writeback. It stalls the pipe through in_ready.

Parameters:
- XLEN, 64, datapath width; legal values are 32 and 64.
- SHAMT_W, $clog2(XLEN), shift-amount width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation
- alu_op  in  2  00 ld/sd, 01 branch, 10 R/I-type
- funct7  in  7  instruction funct7
- funct3  in  3  instruction funct3
- op_a  in  XLEN  operand A / dividend / multiplicand
- op_b  in  XLEN  operand B / divisor / multiplier / shamt
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- result  out  XLEN  result
- zero  out  1  result == 0 (branch compare)
- illegal  out  1  opcode combination not decoded
- busy  out  1  iterative operation in progress

Behaviour:
- Clock and reset: single clock domain clk. reset is synchronous and active-high.
- Reset values: in_ready=1 and busy=0; out_valid, result, zero and illegal are all 0. FSM goes to IDLE.
- Base decode (ALU codes are unchanged from the existing decoder):
  - alu_op=00 -> ADD.
  - alu_op=10 with funct7 0000000/0100000 -> ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - Shifts decode for alu_op 00, 01 and 10 when funct7 matches.
  - alu_op=01: funct3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU.
- M-extension decode: alu_op=10 with funct7=0000001 gives funct3 000..111 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Illegal ops: any other combination sets illegal=1 and result=0, with 1-cycle latency.
- Shifts use op_b[SHAMT_W-1:0] only. SLT/SLTU return 0 or 1, zero-extended.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. An accept happens on in_valid & in_ready; operands and op are latched.
  - Base op or illegal: go to DONE. Result is registered and out_valid=1 on the next cycle (latency 1).
  - MUL/DIV family: go to CALC with busy=1 and a counter loaded to XLEN.
  - CALC: one bit per cycle. Multiply is radix-2 shift-add over magnitudes; divide is restoring. Decrement the counter.
  - CALC exit: when the counter reaches 0, apply sign fix-up and go to DONE. out_valid rises exactly XLEN+1 cycles after the accept edge.
  - DONE: result, zero and illegal are held stable while out_valid=1 and out_ready=0. On out_ready, go to IDLE and clear out_valid.
  - No same-cycle DONE->accept: in_ready is 0 in DONE, giving one bubble per op.
- MUL variants: the product is 2*XLEN bits.
  - MUL selects the low half; MULH/MULHSU/MULHU select the high half.
  - Signedness: MULH treats both operands as signed; MULHSU has A signed and B unsigned; MULHU treats both as unsigned.
- Divide special cases (resolved in IDLE, 1-cycle latency, skip CALC):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give op_a.
  - DIV with op_a = most-negative and op_b = -1: quotient op_a, REM 0.
- Sign rules: quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Reset mid-operation: aborts CALC or DONE immediately, and outputs return to reset values.
- Held inputs: in_valid held high while busy has no effect. Inputs are sampled only on accept.

Optional Feature:
- Macro MEXT_DIV_EN.
- Defined: DIV/DIVU/REM/REMU are implemented as above.
- Undefined: the divider datapath is not compiled. funct3 100..111 under funct7=0000001 decode as illegal (illegal=1, result=0, 1-cycle latency). MUL variants are unaffected.

Decomposition:
- Package alu_pkg:
  - typedef alu_sel_t (5-bit): base codes 0_0000..0_1001 equal to the legacy 4-bit codes; MUL..REMU = 1_0000..1_0111.
  - Constants: ALUOP_MEM, ALUOP_BR, ALUOP_R; F7_BASE, F7_ALT, F7_MEXT.
  - typedef state_t {IDLE, CALC, DONE}.
- Sub-module alu_decode: purely combinational. Maps {alu_op, funct7, funct3} to alu_sel_t plus illegal. It is reused by the forwarding/hazard logic to detect multi-cycle ops.
- The iterative mul/div datapath stays inside the top module.

Test Plan (XLEN=32 unless noted):
- Base op: ADD a=5 b=7 with out_ready=1 -> out_valid on cycle 1, result=12, zero=0. Then BEQ-style SUB a=b=9 -> result=0, zero=1.
- Shift and illegal: SRA a=0x80000000 b=0x24 -> shamt 4, result 0xF8000000. funct7=0111111 -> illegal=1, result=0.
- Multiply: MULH a=-2 b=3 -> out_valid exactly 33 cycles after accept, result 0xFFFFFFFF. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. busy=1 throughout CALC and in_ready=0.
- Divide: DIV a=-7 b=2 -> result -3; REM -> -1; DIVU a=7 b=0 -> 0xFFFFFFFF in 1 cycle; DIV 0x80000000 / -1 -> 0x80000000.
- Backpressure and reset: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0. Assert reset on CALC cycle 10 -> next cycle out_valid=0, busy=0, in_ready=1.
- MEXT_DIV_EN undefined: DIV op -> illegal=1, result=0, latency 1. MUL 6*7 -> 42 after 33 cycles.
